// File: rtl/bus_mem_slave_pkg.sv
// bus_mem_slave_pkg: shared beat/phase encodings and bus widths
// for bus_mem_slave and its mem_array_r register file.
package bus_mem_slave_pkg;

  localparam int ADDR_BUS_W = 16;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    BEAT_IDLE   = 2'b00,
    BEAT_WR_HIT = 2'b01,
    BEAT_RD_HIT = 2'b10,
    BEAT_MISS   = 2'b11
  } beat_t;

  typedef enum logic {
    RESP_IDLE   = 1'b0,
    RESP_ACTIVE = 1'b1
  } phase_t;

endpackage

// File: rtl/bus_mem_slave_mem_array_r.sv
// mem_array_r: 2^ADDR_W x DATA_W register array, async clear, write enable,
// combinational read. Ports: clk, reset_n, we, idx, wdata -> rdata.
module mem_array_r #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word memory responder on the 16b addr / 32b data bus.
// Ports: s_sel/s_wr/s_addr/s_din in, s_dout/s_ack/s_err out, sticky
// err_flag (err_clear), access counters rd_cnt/wr_cnt (cnt_clear) built
// only when ACCESS_CNT_EN is defined; otherwise the counters read 0.
module bus_mem_slave
  import bus_mem_slave_pkg::*;
#(
  parameter int                    ADDR_W    = 5,
  parameter logic [ADDR_BUS_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_sel,
  input  logic                  s_wr,
  input  logic [ADDR_BUS_W-1:0] s_addr,
  input  logic [DATA_W-1:0]     s_din,
  output logic [DATA_W-1:0]     s_dout,
  output logic                  s_ack,
  output logic                  s_err,
  output logic                  err_flag,
  input  logic                  err_clear,
  input  logic                  cnt_clear,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
);

  logic              hit;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rdata;
  beat_t             beat;
  beat_t             beat_q;
  phase_t            phase_q;
  phase_t            phase_d;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              flag_q;
  logic              flag_d;

  assign hit = s_addr[ADDR_BUS_W-1:ADDR_W]
            == BASE_ADDR[ADDR_BUS_W-1:ADDR_W];
  assign idx = s_addr[ADDR_W-1:0];

  always_comb begin
    beat = BEAT_IDLE;
    unique case (1'b1)
      !s_sel:                beat = BEAT_IDLE;
      s_sel && !hit:         beat = BEAT_MISS;
      s_sel && hit && s_wr:  beat = BEAT_WR_HIT;
      s_sel && hit && !s_wr: beat = BEAT_RD_HIT;
      default:               beat = BEAT_IDLE;
    endcase
  end

  mem_array_r #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (beat == BEAT_WR_HIT),
    .idx     (idx),
    .wdata   (s_din),
    .rdata   (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= RESP_IDLE;
      beat_q  <= BEAT_IDLE;
      dout_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      beat_q  <= beat;
      dout_q  <= dout_d;
      flag_q  <= flag_d;
    end
  end

  // A miss in the clear cycle keeps the flag set.
  always_comb begin
    phase_d = RESP_IDLE;
    dout_d  = '0;
    flag_d  = flag_q;
    if (beat != BEAT_IDLE) phase_d = RESP_ACTIVE;
    if (beat == BEAT_RD_HIT) dout_d = rdata;
    if (beat == BEAT_MISS) begin
      flag_d = 1'b1;
    end else if (err_clear) begin
      flag_d = 1'b0;
    end
  end

  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    if (phase_q == RESP_ACTIVE) begin
      unique case (beat_q)
        BEAT_WR_HIT: s_ack = 1'b1;
        BEAT_RD_HIT: s_ack = 1'b1;
        BEAT_MISS:   s_err = 1'b1;
        default:     s_ack = 1'b0;
      endcase
    end
  end

  assign s_dout   = dout_q;
  assign err_flag = flag_q;

`ifdef ACCESS_CNT_EN
  logic [15:0] rd_q;
  logic [15:0] wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
      wr_q <= '0;
    end else if (cnt_clear) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      if (beat == BEAT_RD_HIT && rd_q != 16'hFFFF) rd_q <= rd_q + 16'd1;
      if (beat == BEAT_WR_HIT && wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
    end
  end

  assign rd_cnt = rd_q;
  assign wr_cnt = wr_q;
`else
  logic cnt_clear_unused;
  assign cnt_clear_unused = cnt_clear;
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: scoreboard bench for bus_mem_slave; expected responses
// are queued per driven beat and compared on the following cycle.
module tb_bus_mem_slave;

  localparam int          AW   = 5;
  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_wr = 1'b0;
  logic [15:0] s_addr = '0;
  logic [31:0] s_din = '0;
  logic [31:0] s_dout;
  logic        s_ack;
  logic        s_err;
  logic        err_flag;
  logic        err_clear = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  bus_mem_slave #(
    .ADDR_W    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .err_flag  (err_flag),
    .err_clear (err_clear),
    .cnt_clear (cnt_clear),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dout;
    logic        flag;
    logic [15:0] rd;
    logic [15:0] wr;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mm [2**AW];
  logic        m_flag;
  logic [15:0] m_rd;
  logic [15:0] m_wr;
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) mm[i] = '0;
    m_flag = 1'b0;
    m_rd   = '0;
    m_wr   = '0;
  endtask

  task automatic check_front();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("ack", {31'd0, s_ack}, {31'd0, e.ack});
      chk("err", {31'd0, s_err}, {31'd0, e.err});
      chk("dout", s_dout, e.dout);
      chk("flag", {31'd0, err_flag}, {31'd0, e.flag});
      chk("rd_cnt", {16'd0, rd_cnt}, {16'd0, e.rd});
      chk("wr_cnt", {16'd0, wr_cnt}, {16'd0, e.wr});
    end
  endtask

  task automatic push_exp(input logic sel, input logic wr,
                          input logic [15:0] addr, input logic [31:0] din,
                          input logic ec, input logic cc);
    exp_t        e;
    logic        hit;
    logic [AW-1:0] ix;
    hit = (addr >> AW) == (BASE >> AW);
    ix  = addr[AW-1:0];
    e.ack  = sel && hit;
    e.err  = sel && !hit;
    e.dout = (sel && hit && !wr) ? mm[ix] : 32'd0;
    if (sel && hit && wr) mm[ix] = din;
    if (sel && !hit) m_flag = 1'b1;
    else if (ec) m_flag = 1'b0;
`ifdef ACCESS_CNT_EN
    if (cc) begin
      m_rd = '0;
      m_wr = '0;
    end else begin
      if (sel && hit && !wr && m_rd != 16'hFFFF) m_rd++;
      if (sel && hit && wr && m_wr != 16'hFFFF) m_wr++;
    end
`endif
    e.flag = m_flag;
    e.rd   = m_rd;
    e.wr   = m_wr;
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic sel, input logic wr,
                     input logic [15:0] addr, input logic [31:0] din,
                     input logic ec = 1'b0, input logic cc = 1'b0);
    @(negedge clk);
    check_front();
    s_sel     = sel;
    s_wr      = wr;
    s_addr    = addr;
    s_din     = din;
    err_clear = ec;
    cnt_clear = cc;
    push_exp(sel, wr, addr, din, ec, cc);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_dout"}, s_dout, 32'd0);
    chk({tag, "_ack"}, {31'd0, s_ack}, 32'd0);
    chk({tag, "_err"}, {31'd0, s_err}, 32'd0);
    chk({tag, "_flag"}, {31'd0, err_flag}, 32'd0);
    chk({tag, "_cnt"}, {rd_cnt, wr_cnt}, 32'd0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    check_front();
    s_sel   = 1'b1;
    s_wr    = 1'b1;
    s_addr  = 16'h0003;
    s_din   = 32'h12345678;
    reset_n = 1'b0;
    #1;
    reset_check("rst_async");
    @(negedge clk);
    reset_check("rst_hold");
    s_sel     = 1'b0;
    s_wr      = 1'b0;
    s_addr    = '0;
    s_din     = '0;
    err_clear = 1'b0;
    cnt_clear = 1'b0;
    model_clear();
    reset_n = 1'b1;
    push_exp(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    model_clear();
    #2;
    reset_check("rst_init");
    @(negedge clk);
    reset_n = 1'b1;
    push_exp(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);

    // write then immediate read
    cyc(1'b1, 1'b1, 16'h0005, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 16'h0005, 32'h0);
    idle();

    // reset mid-stream, idx 3 must read back 0
    cyc(1'b1, 1'b1, 16'h0003, 32'hAAAA5555);
    mid_reset();
    cyc(1'b1, 1'b0, 16'h0003, 32'h0);
    cyc(1'b1, 1'b0, 16'h0005, 32'h0);

    // DMA-style burst: src 0..3 -> dest 16..19
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 16'(i), 32'(i + 1));
`ifdef ACCESS_CNT_EN
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'(i), 32'h0);
      cyc(1'b1, 1'b1, 16'(16 + i), 32'(i + 1));
    end
    idle();
    for (int i = 16; i < 20; i++) cyc(1'b1, 1'b0, 16'(i), 32'h0);

    // miss on descriptor-pop address
    cyc(1'b1, 1'b1, 16'h001F, 32'h0000001F);
    cyc(1'b1, 1'b0, 16'hFFFF, 32'h0);
    idle();
    idle();
    cyc(1'b1, 1'b1, 16'hFFFF, 32'h00000BAD);
    cyc(1'b1, 1'b0, 16'h001F, 32'h0);
    cyc(1'b1, 1'b0, 16'h0020, 32'h0);

    // error clear race
    cyc(1'b1, 1'b0, 16'hFFFF, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    idle();

    // back-to-back read-after-write on random data
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 16'($urandom_range(0, 31)), $urandom);
      cyc(1'b1, 1'b0, s_addr, 32'h0);
    end
    idle();

`ifdef ACCESS_CNT_EN
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 65537; i++) cyc(1'b1, 1'b1, 16'h0007, 32'(i));
    idle();
    cyc(1'b1, 1'b0, 16'h0007, 32'h0);
    cyc(1'b1, 1'b0, 16'h0007, 32'h0, 1'b0, 1'b1);
    idle();
`endif

    idle();
    @(negedge clk);
    check_front();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Single-port, word-addressed memory responder on the shared 16-bit address / 32-bit data bus.
- Serves the DMA master's READ/WRITE beats: captures writes and returns read data one cycle after the address phase, which is the cycle the master's WRITE beat consumes it.
- Decodes its own address window and flags accesses that miss the window.
- Several instances sit behind the bus arbiter: source and destination memories.

Parameters:
- ADDR_W, 5, word-index width; depth = 2^ADDR_W words (legal 2..12).
- BASE_ADDR, 16'h0000, window base; must be aligned to 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s_sel  in  1  slave selected; the arbiter drives it from the granted master's m_req
- s_wr  in  1  1 = write beat, 0 = read beat (from m_wr)
- s_addr  in  16  word address (from m_addr)
- s_din  in  32  write data (from m_dout)
- s_dout  out  32  registered read data (to the master's m_din)
- s_ack  out  1  registered; accepted in-window beat, one cycle after the beat
- s_err  out  1  registered one-cycle pulse; out-of-window beat
- err_flag  out  1  sticky error status
- err_clear  in  1  clears err_flag
- cnt_clear  in  1  clears access counters (ACCESS_CNT_EN)
- rd_cnt  out  16  read-beat counter
- wr_cnt  out  16  write-beat counter

Behaviour:
- Reset: clk and reset_n; reset is asynchronous and active-low. While reset_n=0:
  - s_dout=0, s_ack=0, s_err=0, err_flag=0, rd_cnt=0, wr_cnt=0.
  - Every memory word cleared to 0.
  - Reset mid-access discards the beat; no partial write.
- hit = s_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]; idx = s_addr[ADDR_W-1:0].
- Beat types, one per cycle while s_sel=1:
  - WR_HIT: s_wr=1, hit=1. mem[idx] <= s_din at the edge; next cycle s_ack=1, s_dout=0.
  - RD_HIT: s_wr=0, hit=1. Next cycle s_dout=mem[idx] and s_ack=1. Latency is exactly 1 cycle.
  - MISS: hit=0, read or write. No memory change; next cycle s_dout=0, s_ack=0, s_err=1; err_flag set.
  - IDLE: s_sel=0. Next cycle s_dout=0, s_ack=0, s_err=0.
- Read-after-write: a WR_HIT at cycle N followed by an RD_HIT to the same idx at N+1 returns the new data at N+2.
- Back-to-back beats are accepted every cycle with no stall. No wait states, no backpressure.
- s_dout holds its value only for the cycle after the read. The master samples it in that cycle.
- err_flag:
  - err_clear=1 clears it at the next edge.
  - A MISS in the same cycle as err_clear wins: the flag stays 1.
- Address 16'hFFFF: an ordinary MISS unless BASE_ADDR covers the top window. The master drives it with m_req=1 during descriptor pops.
- Internal control is a 2-state registered phase:
  - RESP_IDLE: no beat last cycle.
  - RESP_ACTIVE: a beat was captured last cycle.
  - The outputs are decoded from the latched beat type: WR_HIT, RD_HIT or MISS.

Optional Feature:
- ACCESS_CNT_EN defined:
  - rd_cnt and wr_cnt count accepted RD_HIT and WR_HIT beats respectively, 16-bit, saturating at 16'hFFFF (no wrap).
  - MISS beats are not counted.
  - cnt_clear=1 zeroes both counters; a coincident beat is dropped from the count (clear wins).
- ACCESS_CNT_EN undefined: rd_cnt=wr_cnt=0 constant, cnt_clear ignored, no counter flops.

Decomposition:
- Shared package holds:
  - beat-type encoding (IDLE, WR_HIT, RD_HIT, MISS as 2'b00..2'b11);
  - RESP_IDLE/RESP_ACTIVE encoding;
  - bus widths ADDR_BUS_W=16 and DATA_W=32.
- One sub-module: mem_array_r.
  - 2^ADDR_W x 32 register array with asynchronous clear, write enable, and combinational read by index.
- Decode, response registers, error logic and counters live in the top module.

Test Plan:
- Reset check: assert reset_n=0 mid-stream, then release. All outputs are 0; a read of idx 3 returns 0; no s_ack.
- Write/read: BASE=0. Write 32'hDEADBEEF to addr 5, then read addr 5 the next cycle. s_ack is seen after each beat; s_dout=32'hDEADBEEF two cycles after the write.
- DMA-style burst: alternate read src 0..3 and write dest 16..19 with preloaded values 1..4. Memory 16..19 holds 1..4. With ACCESS_CNT_EN, rd_cnt=4 and wr_cnt=4.
- Miss on the pop address: s_sel=1, s_wr=0, s_addr=16'hFFFF. Next cycle s_err=1 (one pulse), s_dout=0, s_ack=0; err_flag stays 1. A later write to 16'hFFFF leaves memory unchanged.
- Error clear race: err_clear=1 in the same cycle as a MISS gives err_flag=1. err_clear alone next cycle gives err_flag=0.
- Counter saturation (ACCESS_CNT_EN): 65537 write hits give wr_cnt=16'hFFFF. cnt_clear together with a read hit gives rd_cnt=0.
